// File: rtl/mul_pkg.sv
// Shared definitions for the shift_add_mul multiplier: FSM state type and
// default operand width.
package mul_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pp_gate.sv
// Partial-product gate: passes a vector through when the select bit is set,
// otherwise yields zero.
module pp_gate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] vec,
    input  logic             sel,
    output logic [WIDTH-1:0] gated
);

    assign gated = vec & {WIDTH{sel}};

endmodule

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-and-add multiplier with busy/done handshake.
// One partial product is accumulated per RUN cycle; the product stays on
// the output until the next accepted start clears the accumulator.
// Optional macro SHIFT_ADD_MUL_EARLY_TERM_EN: leave RUN as soon as no set
// multiplier bits remain, so short multipliers finish early.
module shift_add_mul
    import mul_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int COUNT_W = $clog2(WIDTH);

    state_t               state;
    logic [2*WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   pp;
    logic [WIDTH-1:0]     mplier;
    logic [COUNT_W-1:0]   count;
    logic                 last;

    pp_gate #(.WIDTH(WIDTH)) u_pp_lo (
        .vec   (mcand[WIDTH-1:0]),
        .sel   (mplier[0]),
        .gated (pp[WIDTH-1:0])
    );

    pp_gate #(.WIDTH(WIDTH)) u_pp_hi (
        .vec   (mcand[2*WIDTH-1:WIDTH]),
        .sel   (mplier[0]),
        .gated (pp[2*WIDTH-1:WIDTH])
    );

`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
    // Finish after the last bit, or once the shifted-out multiplier is empty.
    assign last = (count == COUNT_W'(WIDTH - 1)) || (mplier[WIDTH-1:1] == '0);
`else
    // Fixed latency: every multiplier bit gets its own cycle.
    assign last = (count == COUNT_W'(WIDTH - 1));
`endif

    // FSM and datapath: latch operands on start, accumulate/shift in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        count  <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign product = acc;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboard testbench for shift_add_mul: driver pushes expected product and
// RUN-cycle count per issued operation; a monitor pops and compares on done.
module tb_shift_add_mul;
    import mul_pkg::*;

    localparam int WIDTH = 32;

    logic               clk;
    logic               rst;
    logic               start;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    int checks   = 0;
    int failures = 0;

    logic [2*WIDTH-1:0] sb_prod[$];
    int                 sb_cyc[$];

    shift_add_mul #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int exp_cycles(input logic [WIDTH-1:0] bv);
`ifdef SHIFT_ADD_MUL_EARLY_TERM_EN
        int m = 1;
        for (int i = 0; i < WIDTH; i++) begin
            if (bv[i]) m = i + 1;
        end
        return m;
`else
        return WIDTH;
`endif
    endfunction

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: count RUN cycles and score each done pulse.
    int   run_cnt   = 0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            run_cnt   = 0;
            prev_done = 1'b0;
        end else begin
            if (busy && !done) run_cnt++;
            if (done) begin
                checks++;
                if (prev_done) begin
                    failures++;
                    $display("FAIL done_pulse_width actual=2+ required=1");
                end
                if (sb_prod.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done required=no_done product=%h", product);
                end else begin
                    logic [2*WIDTH-1:0] ep;
                    int                 ec;
                    ep = sb_prod.pop_front();
                    ec = sb_cyc.pop_front();
                    checks++;
                    if (product !== ep) begin
                        failures++;
                        $display("FAIL product actual=%h required=%h", product, ep);
                    end
                    checks++;
                    if (run_cnt != ec) begin
                        failures++;
                        $display("FAIL run_cycles actual=%0d required=%0d", run_cnt, ec);
                    end
                end
                run_cnt = 0;
            end
            prev_done = done;
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 2 * WIDTH + 10; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        check1("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                            input logic [2*WIDTH-1:0] ep);
        wait_idle();
        start = 1'b1;
        a     = av;
        b     = bv;
        sb_prod.push_back(ep);
        sb_cyc.push_back(exp_cycles(bv));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < WIDTH + 10; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check1("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                          input logic [2*WIDTH-1:0] ep);
        start_op(av, bv, ep);
        wait_done();
        @(negedge clk);
        check1("busy_after_done", 64'(busy), 64'd0);
        check1("product_hold", product, ep);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check1("reset_busy", 64'(busy), 64'd0);
        check1("reset_done", 64'(done), 64'd0);
        check1("reset_product", product, 64'd0);
        rst = 1'b0;

        // Directed vectors with hand-computed products.
        run_op(32'd7, 32'd6, 64'd42);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(32'd123, 32'd0, 64'd0);
        run_op(32'd1, 32'h8000_0000, 64'h0000_0000_8000_0000);
        run_op(32'hFFFF_FFFF, 32'd1, 64'h0000_0000_FFFF_FFFF);
        run_op(32'h1234_5678, 32'd16, 64'h0000_0001_2345_6780);
        run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);

        // Start held high across two operations; operand changes while busy
        // must not be picked up.
        wait_idle();
        start = 1'b1;
        a = 32'd3;
        b = 32'd5;
        sb_prod.push_back(64'd15);
        sb_cyc.push_back(exp_cycles(32'd5));
        @(posedge clk);
        repeat (2) @(negedge clk);
        a = 32'd99;
        b = 32'd99;
        wait_done();
        a = 32'd10;
        b = 32'd10;
        sb_prod.push_back(64'd100);
        sb_cyc.push_back(exp_cycles(32'd10));
        @(posedge clk);
        #1 check1("idle_after_done_held_start", 64'(busy), 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        check1("held_start_accepted_in_idle", 64'(busy), 64'd1);
        wait_done();
        @(negedge clk);
        check1("held_second_hold", product, 64'd100);

        // Reset in the middle of RUN aborts without a done pulse.
        wait_idle();
        start = 1'b1;
        a = 32'hDEAD_BEEF;
        b = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check1("abort_busy", 64'(busy), 64'd0);
        check1("abort_done", 64'(done), 64'd0);
        check1("abort_product", product, 64'd0);
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        start = 1'b1;
        a     = 32'd2;
        b     = 32'd2;
        sb_prod.push_back(64'd4);
        sb_cyc.push_back(exp_cycles(32'd2));
        @(posedge clk);
        #1 start = 1'b0;
        check1("start_after_reset_accepted", 64'(busy), 64'd1);
        wait_done();
        @(negedge clk);
        check1("post_reset_product", product, 64'd4);

        // Back-to-back operations against a reference multiply.
        for (int i = 0; i < 40; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = $urandom();
            rb = $urandom() >> $urandom_range(0, 31);
            start_op(ra, rb, 64'(ra) * 64'(rb));
            wait_done();
        end
        @(negedge clk);

        check1("scoreboard_empty", 64'(sb_prod.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
